// File: rtl/bin_to_bcd3.sv
// Sequential double-dabble converter: unsigned binary to three held BCD digits, one bit per clock.
// Optional macro BCD_SATURATE_EN: inputs above 999 display 9,9,9 instead of value mod 1000.

module bin_to_bcd3 #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       x0,
    output logic [3:0]       x1,
    output logic [3:0]       x2
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            r_state, w_state_next;
    logic [WIDTH-1:0]  r_sr, w_sr_next;
    logic [11:0]       r_bcd, w_bcd_next, w_bcd_adj;
    logic [CntW-1:0]   r_cnt, w_cnt_next;
    logic              r_ovf_pend, w_ovf_pend_next;
    logic [11:0]       r_x, w_x_next;
    logic              r_ovf, w_ovf_next;
    logic              r_done, w_done_next;
    logic [WIDTH+11:0] w_shift;

    // Add-3 correction per digit; no carry between digits.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The thousands carry falls off the top, leaving value mod 1000.
    assign w_shift = {w_bcd_adj, r_sr} << 1;

    always_comb begin
        w_state_next    = r_state;
        w_sr_next       = r_sr;
        w_bcd_next      = r_bcd;
        w_cnt_next      = r_cnt;
        w_ovf_pend_next = r_ovf_pend;
        w_x_next        = r_x;
        w_ovf_next      = r_ovf;
        w_done_next     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_sr_next       = bin;
                    w_bcd_next      = 12'h000;
                    w_cnt_next      = CntLoad;
                    w_ovf_pend_next = 32'(bin) > 32'd999;
                    w_state_next    = StShift;
                end
            end
            StShift: begin
                w_bcd_next = w_shift[WIDTH+11:WIDTH];
                w_sr_next  = w_shift[WIDTH-1:0];
                w_cnt_next = r_cnt - CntLast;
                if (r_cnt == CntLast) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
`ifdef BCD_SATURATE_EN
                w_x_next = r_ovf_pend ? 12'h999 : r_bcd;
`else
                w_x_next = r_bcd;
`endif
                w_ovf_next   = r_ovf_pend;
                w_done_next  = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_sr       <= '0;
            r_bcd      <= 12'h000;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_x        <= 12'h000;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sr       <= w_sr_next;
            r_bcd      <= w_bcd_next;
            r_cnt      <= w_cnt_next;
            r_ovf_pend <= w_ovf_pend_next;
            r_x        <= w_x_next;
            r_ovf      <= w_ovf_next;
            r_done     <= w_done_next;
        end
    end

    assign busy = (r_state != StIdle);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign x0   = r_x[3:0];
    assign x1   = r_x[7:4];
    assign x2   = r_x[11:8];

endmodule

// File: tb/tb_bin_to_bcd3.sv
// Self-checking bench for bin_to_bcd3: directed vector table on WIDTH=10, reset abort,
// back-to-back handshake, and an exhaustive WIDTH=8 sweep.

module tb_bin_to_bcd3;

    typedef struct {
        logic [9:0]  bin;
        logic [11:0] x;
        logic        ovf;
    } vec_t;

`ifdef BCD_SATURATE_EN
    localparam logic [11:0] Exp1023 = 12'h999;
    localparam logic [11:0] Exp1000 = 12'h999;
`else
    localparam logic [11:0] Exp1023 = 12'h023;
    localparam logic [11:0] Exp1000 = 12'h000;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       start10, start8;
    logic [9:0] bin10;
    logic [7:0] bin8;
    logic       busy10, done10, ovf10, busy8, done8, ovf8;
    logic [3:0] a0, a1, a2, b0, b1, b2;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] prev_x;
    logic        prev_ovf;
    vec_t        vecs[11];
    logic [9:0]  hs_vals[48];

    always #5 clock = ~clock;

    bin_to_bcd3 #(.WIDTH(10)) dut10 (
        .clock(clock), .reset(reset), .start(start10), .bin(bin10),
        .busy(busy10), .done(done10), .ovf(ovf10), .x0(a0), .x1(a1), .x2(a2)
    );

    bin_to_bcd3 #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .ovf(ovf8), .x0(b0), .x1(b1), .x2(b2)
    );

    function automatic logic [11:0] bcd_of(input int v);
        int m;
        m = v % 1000;
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One conversion on the WIDTH=10 instance, with stray starts and bin noise while busy.
    task automatic run10(input string name, input logic [9:0] b, input logic [11:0] exp_x,
                         input logic exp_ovf);
        int lat;
        int busy_cnt;
        bit seen;
        bit held_ok;
        lat = 0;
        busy_cnt = 0;
        seen = 0;
        held_ok = 1;
        bin10 = b;
        start10 = 1'b1;
        @(posedge clock); #1;
        start10 = 1'b0;
        while (!seen && lat < 30) begin
            if (busy10) busy_cnt++;
            if (done10) begin
                seen = 1;
                start10 = 1'b0;
            end else begin
                if ({a2, a1, a0} !== prev_x || ovf10 !== prev_ovf) held_ok = 0;
                bin10 = 10'($urandom);
                start10 = 1'(lat % 2);
                @(posedge clock); #1;
                lat++;
            end
        end
        start10 = 1'b0;
        check({name, "_latency"}, lat, 11);
        check({name, "_busy_cycles"}, busy_cnt, 11);
        check({name, "_digits"}, {a2, a1, a0}, exp_x);
        check({name, "_ovf"}, ovf10, exp_ovf);
        check({name, "_held"}, held_ok, 1);
        @(posedge clock); #1;
        check({name, "_done_width"}, done10, 0);
        check({name, "_hold_after"}, {a2, a1, a0}, exp_x);
        check({name, "_idle_after"}, busy10, 0);
        prev_x = exp_x;
        prev_ovf = exp_ovf;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int done_cnt;

        vecs[0]  = '{10'd108,  12'h108, 1'b0};
        vecs[1]  = '{10'd0,    12'h000, 1'b0};
        vecs[2]  = '{10'd999,  12'h999, 1'b0};
        vecs[3]  = '{10'd9,    12'h009, 1'b0};
        vecs[4]  = '{10'd990,  12'h990, 1'b0};
        vecs[5]  = '{10'd1023, Exp1023, 1'b1};
        vecs[6]  = '{10'd255,  12'h255, 1'b0};
        vecs[7]  = '{10'd512,  12'h512, 1'b0};
        vecs[8]  = '{10'd1000, Exp1000, 1'b1};
        vecs[9]  = '{10'd500,  12'h500, 1'b0};
        vecs[10] = '{10'd1023, Exp1023, 1'b1};

        reset = 1'b1;
        start10 = 1'b0;
        start8 = 1'b0;
        bin10 = 10'd0;
        bin8 = 8'd0;
        prev_x = 12'h000;
        prev_ovf = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", busy10, 0);
        check("reset_done", done10, 0);
        check("reset_ovf", ovf10, 0);
        check("reset_digits", {a2, a1, a0}, 0);
        check("reset_busy8", busy8, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 11; i++) begin
            run10($sformatf("vec%0d", i), vecs[i].bin, vecs[i].x, vecs[i].ovf);
        end

        // Abort a conversion with an asynchronous mid-cycle reset.
        bin10 = 10'd512;
        start10 = 1'b1;
        @(posedge clock); #1;
        start10 = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_busy", busy10, 0);
        check("abort_done", done10, 0);
        check("abort_ovf", ovf10, 0);
        check("abort_digits", {a2, a1, a0}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (done10 || busy10) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        prev_x = 12'h000;
        prev_ovf = 1'b0;
        run10("after_abort", 10'd512, 12'h512, 1'b0);

        // start held high: accepts at every 12th edge, results track bin at the accepting edge.
        for (int k = 0; k < 48; k++) hs_vals[k] = 10'((k * 37 + 101) % 1000);
        start10 = 1'b1;
        for (int k = 0; k < 48; k++) begin
            bin10 = hs_vals[k];
            @(posedge clock); #1;
            check($sformatf("hs_done_%0d", k), done10, (k % 12) == 11);
            check($sformatf("hs_busy_%0d", k), busy10, (k % 12) != 11);
            if ((k % 12) == 11) begin
                check($sformatf("hs_digits_%0d", k), {a2, a1, a0}, bcd_of(int'(hs_vals[k-11])));
            end
        end
        start10 = 1'b0;
        @(posedge clock); #1;
        check("hs_idle", busy10, 0);

        for (int v = 0; v < 256; v++) begin
            bin8 = 8'(v);
            start8 = 1'b1;
            @(posedge clock); #1;
            start8 = 1'b0;
            lat = 0;
            while (!done8 && lat < 20) begin
                @(posedge clock); #1;
                lat++;
            end
            check($sformatf("sw_lat_%0d", v), lat, 9);
            check($sformatf("sw_val_%0d", v), 32'(b2) * 100 + 32'(b1) * 10 + 32'(b0), v);
            check($sformatf("sw_ovf_%0d", v), ovf8, 0);
            @(posedge clock); #1;
            check($sformatf("sw_width_%0d", v), done8, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
